// File: rtl/busca_instrucao.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack memory handshake
// and hands each instruction to decode over valid/ready, applying redirects.
module busca_instrucao #(
  parameter logic [31:0] PC_RESET = 32'h0040_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        iCLK,
  input  logic        iRST,
  output logic        oMemReq,
  output logic [31:0] oMemAddr,
  input  logic        iMemAck,
  input  logic [31:0] iMemData,
  output logic        oValid,
  output logic [31:0] oInst,
  output logic [31:0] oPC,
  input  logic        iReady,
  input  logic        iRedirect,
  input  logic [31:0] iTarget,
  output logic        oFault,
  output logic [31:0] oCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic [31:0] r_count;
  logic [31:0] w_next_pc;
  logic        w_misaligned;
  logic        w_consume;

  // Redirect inputs only matter on the consuming edge; elsewhere they are don't-care.
  assign w_consume    = (r_state == S_HOLD) && iReady;
  assign w_next_pc    = iRedirect ? iTarget : (r_inst_pc + 32'd4);
  assign w_misaligned = |w_next_pc[1:0];

  always_comb begin
    // NOTE: default first so every path assigns w_state_next and no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = S_REQ;
      S_REQ:   if (iMemAck) w_state_next = S_HOLD;
      S_HOLD:  if (iReady) w_state_next = w_misaligned ? S_FAULT : S_REQ;
      default: w_state_next = S_FAULT;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of order.
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_pc      <= PC_RESET;
      r_inst    <= NOP_INST;
      r_inst_pc <= PC_RESET;
      r_count   <= '0;
    end else begin
      if ((r_state == S_REQ) && iMemAck) begin
        r_inst    <= iMemData;
        r_inst_pc <= r_pc;
      end
      if (w_consume) begin
        r_count <= r_count + 32'd1;
        r_inst  <= NOP_INST;
        // A misaligned target leaves pc at the faulting instruction's fetch address.
        if (!w_misaligned) r_pc <= w_next_pc;
      end
    end
  end

  assign oMemReq  = (r_state == S_REQ);
  assign oMemAddr = r_pc;
  assign oValid   = (r_state == S_HOLD);
  assign oInst    = r_inst;
  assign oPC      = r_inst_pc;
  assign oFault   = (r_state == S_FAULT);
  assign oCount   = r_count;

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: directed vector table, hand-built corner sequences
// and random traffic checked against a transaction-level fetch model.
module tb_busca_instrucao;

  localparam logic [31:0] PC_RST = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        ready = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] target = '0;
  logic        fault;
  logic [31:0] count;

  // Second instance exercising the top-of-address-space wrap.
  logic        w_rst = 1'b1;
  logic        w_ack = 1'b0;
  logic        w_ready = 1'b0;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic        wr_valid;
  logic [31:0] wr_inst;
  logic [31:0] wr_pc;
  logic        wr_fault;
  logic [31:0] wr_count;

  always #5 clk = ~clk;

  busca_instrucao dut (
    .iCLK(clk), .iRST(rst),
    .oMemReq(mem_req), .oMemAddr(mem_addr), .iMemAck(mem_ack), .iMemData(mem_data),
    .oValid(valid), .oInst(inst), .oPC(pc), .iReady(ready),
    .iRedirect(redir), .iTarget(target), .oFault(fault), .oCount(count)
  );

  busca_instrucao #(.PC_RESET(32'hFFFF_FFFC)) dut_wrap (
    .iCLK(clk), .iRST(w_rst),
    .oMemReq(wr_req), .oMemAddr(wr_addr), .iMemAck(w_ack), .iMemData(32'h0000_0073),
    .oValid(wr_valid), .oInst(wr_inst), .oPC(wr_pc), .iReady(w_ready),
    .iRedirect(1'b0), .iTarget(32'h0), .oFault(wr_fault), .oCount(wr_count)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: "waiting to fetch", "holding an instruction", "faulted".
  logic        m_started, m_have, m_fault;
  logic [31:0] m_pc, m_inst, m_ipc, m_count;

  task automatic model_reset();
    m_started = 1'b0; m_have = 1'b0; m_fault = 1'b0;
    m_pc = PC_RST; m_inst = NOP; m_ipc = PC_RST; m_count = '0;
  endtask

  task automatic model_update(input logic ack, input logic [31:0] data, input logic rdy,
                              input logic rd, input logic [31:0] tgt);
    logic [31:0] nxt;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (m_fault) begin
      // sticky until reset
    end else if (!m_have) begin
      if (ack) begin
        m_have = 1'b1; m_inst = data; m_ipc = m_pc;
      end
    end else if (rdy) begin
      m_count = m_count + 1;
      nxt     = rd ? tgt : m_ipc + 32'd4;
      m_have  = 1'b0;
      m_inst  = NOP;
      if (nxt % 4 != 0) m_fault = 1'b1;
      else m_pc = nxt;
    end
  endtask

  task automatic compare_all();
    check("oMemReq",  {31'b0, mem_req}, {31'b0, m_started && !m_have && !m_fault});
    check("oMemAddr", mem_addr, m_pc);
    check("oValid",   {31'b0, valid}, {31'b0, m_have});
    check("oInst",    inst, m_have ? m_inst : NOP);
    check("oPC",      pc, m_ipc);
    check("oFault",   {31'b0, fault}, {31'b0, m_fault});
    check("oCount",   count, m_count);
  endtask

  // Called at a falling edge: check, drive the next cycle's inputs, advance the model.
  task automatic step(input logic ack, input logic [31:0] data, input logic rdy,
                      input logic rd, input logic [31:0] tgt);
    compare_all();
    mem_ack = ack; mem_data = data; ready = rdy; redir = rd; target = tgt;
    model_update(ack, data, rdy, rd, tgt);
    @(negedge clk);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge.
  task automatic do_reset(input logic ack_during);
    #2;
    rst = 1'b1; mem_ack = ack_during; mem_data = 32'hBAD0_0001; ready = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk); #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b0; ready = 1'b0; redir = 1'b0;
  endtask

  typedef struct {
    logic        ack;
    logic [31:0] data;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic [31:0] e_count;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0040_0000, 1'b0, NOP,          32'h0040_0000, 32'd0};
    tbl[1] = '{1'b1, 32'h00A0_0093, 1'b1, 1'b1, 32'h0040_0000, 1'b0, NOP,          32'h0040_0000, 32'd0};
    tbl[2] = '{1'b1, 32'hBAD0_0002, 1'b1, 1'b0, 32'h0040_0000, 1'b1, 32'h00A0_0093, 32'h0040_0000, 32'd0};
    tbl[3] = '{1'b1, 32'h0010_8113, 1'b1, 1'b1, 32'h0040_0004, 1'b0, NOP,          32'h0040_0000, 32'd1};
    tbl[4] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0040_0004, 1'b1, 32'h0010_8113, 32'h0040_0004, 32'd1};
    tbl[5] = '{1'b1, 32'h0021_0193, 1'b1, 1'b1, 32'h0040_0008, 1'b0, NOP,          32'h0040_0004, 32'd2};
    tbl[6] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0040_0008, 1'b1, 32'h0021_0193, 32'h0040_0008, 32'd2};
    tbl[7] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h0040_000C, 1'b0, NOP,          32'h0040_0008, 32'd3};

    model_reset();
    @(negedge clk);
    do_reset(1'b0);

    // Zero-wait memory, ready held high.
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tbl%0d.req", i),   {31'b0, mem_req}, {31'b0, tbl[i].e_req});
      check($sformatf("tbl%0d.addr", i),  mem_addr, tbl[i].e_addr);
      check($sformatf("tbl%0d.valid", i), {31'b0, valid}, {31'b0, tbl[i].e_valid});
      check($sformatf("tbl%0d.inst", i),  inst, tbl[i].e_inst);
      check($sformatf("tbl%0d.pc", i),    pc, tbl[i].e_pc);
      check($sformatf("tbl%0d.count", i), count, tbl[i].e_count);
      mem_ack = tbl[i].ack; mem_data = tbl[i].data; ready = tbl[i].rdy; redir = 1'b0;
      model_update(tbl[i].ack, tbl[i].data, tbl[i].rdy, 1'b0, '0);
      @(negedge clk);
    end

    // Slow memory then a stalled consumer; redirect without ready must be ignored.
    step(1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b1, 32'h0031_8213, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'hBAD0_0003, 1'b0, 1'b1, 32'h0040_0100);
    check("stall.pc", pc, 32'h0040_000C);
    step(1'b0, '0, 1'b1, 1'b0, '0);

    // Taken redirect from 0x00400010 back to PC_RESET.
    step(1'b1, 32'h0000_0463, 1'b0, 1'b0, '0);
    check("redir.pc", pc, 32'h0040_0010);
    step(1'b0, '0, 1'b1, 1'b1, 32'h0040_0000);
    check("redir.addr", mem_addr, 32'h0040_0000);
    check("redir.req", {31'b0, mem_req}, 32'd1);

    // Misaligned target: sticky fault, count bumps once, reset clears.
    step(1'b1, 32'h0060_006F, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b1, 1'b1, 32'h0040_0006);
    check("fault.flag", {31'b0, fault}, 32'd1);
    check("fault.count", count, 32'd6);
    for (int i = 0; i < 5; i++) step(1'b1, 32'hBAD0_0004, 1'b1, 1'b0, '0);
    do_reset(1'b0);

    // Reset while waiting for an ack, ack pulsing during reset.
    step(1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b0, '0);
    do_reset(1'b1);
    step(1'b0, '0, 1'b0, 1'b0, '0);
    check("restart.addr", mem_addr, PC_RST);
    step(1'b1, 32'h0000_0013, 1'b1, 1'b0, '0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic        r_ack, r_rdy, r_rd;
      logic [31:0] r_tgt;
      if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(0, 1) == 1);
      end else begin
        r_ack = ($urandom_range(0, 2) == 0);
        r_rdy = ($urandom_range(0, 1) == 0);
        r_rd  = ($urandom_range(0, 3) == 0);
        r_tgt = PC_RST + ($urandom_range(0, 63) * 4);
        if ($urandom_range(0, 39) == 0) r_tgt = r_tgt + $urandom_range(1, 3);
        step(r_ack, $urandom, r_rdy, r_rd, r_tgt);
      end
    end
    compare_all();

    // PC wrap at the top of the address space.
    @(negedge clk);
    w_rst = 1'b0; w_ack = 1'b1; w_ready = 1'b1;
    @(negedge clk);
    check("wrap.addr0", wr_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap.pc", wr_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap.addr", wr_addr, 32'h0000_0000);
    check("wrap.req", {31'b0, wr_req}, 32'd1);
    check("wrap.fault", {31'b0, wr_fault}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction fetch stage of the single-cycle RISC-V core. Holds the program counter, issues requests to instruction memory through a req/ack handshake, and presents each fetched instruction with its PC to the decode/control stage under a valid/ready handshake. Applies redirects (taken BEQ, JAL) resolved for the presented instruction, and stops in a sticky fault state on a misaligned target.

## Interface
- PC_RESET, 32'h0040_0000, PC of the first fetch after reset
- NOP_INST, 32'h0000_0013, value driven on oInst while no valid instruction is held (addi x0,x0,0)

Ports:
- iCLK  in  1  clock, all state updates on rising edge
- iRST  in  1  reset, asynchronous, active-high
- oMemReq  out  1  fetch request to instruction memory
- oMemAddr  out  32  fetch address; stable while oMemReq=1
- iMemAck  in  1  memory returns iMemData this cycle; sampled only while oMemReq=1
- iMemData  in  32  instruction word from memory
- oValid  out  1  oInst/oPC hold a fetched instruction
- oInst  out  32  instruction to decode/control stage
- oPC  out  32  address of oInst
- iReady  in  1  downstream consumes oInst this cycle when oValid=1
- iRedirect  in  1  presented instruction redirects flow (taken branch or jump); qualified by oValid&iReady
- iTarget  in  32  redirect target, valid with iRedirect
- oFault  out  1  sticky misaligned-target fault
- oCount  out  32  number of instructions consumed downstream, wraps

## Operation
- Internal registers: pc (32), state, inst buffer, count.
- States: IDLE, REQ, HOLD, FAULT.
- IDLE: entered on reset; next cycle -> REQ. Outputs all at reset values.
- REQ: oMemReq=1, oMemAddr=pc. On iMemAck=1: latch iMemData into oInst, oPC<=pc, oValid<=1, -> HOLD. Otherwise stay; address must not change.
- HOLD: oMemReq=0, oValid=1, oInst/oPC stable. On iReady=1:
  - count <= count+1 (mod 2^32).
  - next = iRedirect ? iTarget : oPC+4 (32-bit, wraps 32'hFFFF_FFFC -> 0).
  - if next[1:0]!=0: oFault<=1, oValid<=0, oInst<=NOP_INST, -> FAULT; pc unchanged.
  - else pc<=next, oValid<=0, oInst<=NOP_INST, -> REQ.
  - iRedirect/iTarget are ignored when oValid=0 or iReady=0.
- FAULT: oMemReq=0, oValid=0, oFault=1; held until iRST.
- iMemAck outside REQ is ignored.

## Timing
- Reset values: oMemReq=0, oMemAddr=PC_RESET, oValid=0, oInst=NOP_INST, oPC=PC_RESET, oFault=0, oCount=0, state=IDLE, pc=PC_RESET.
- Reset is asynchronous: mid-request or mid-hold, all outputs return to reset values immediately; any in-flight memory ack after release is ignored until REQ is re-entered (first ack after release is accepted only in REQ).
- First request: oMemReq rises on the first edge after iRST deasserts (IDLE lasts one cycle).
- Zero-wait memory (ack in first REQ cycle): oValid asserted the cycle after; with iReady=1 held, throughput is one instruction per 2 cycles.
- N-cycle memory: oValid rises the cycle after the cycle iMemAck=1.
- oCount increments at the edge where oValid&iReady=1, visible the next cycle.
- Redirect and fault decisions use iTarget sampled at that same edge.

## Test plan
- Reset release with zero-wait memory, iReady=1: oMemAddr sequence 0x00400000, 0x00400004, 0x00400008; oValid pulses every 2nd cycle; oCount=3 after third consumption.
- Memory ack delayed 3 cycles, iReady=0 for 4 cycles in HOLD: oMemAddr stable throughout REQ; oInst/oPC stable during HOLD; no second request issued.
- Presented instruction at 0x00400010 with iRedirect=1, iTarget=0x00400000 and iReady=1: next oMemAddr=0x00400000; iRedirect=1 with iReady=0 has no effect.
- iRedirect=1, iTarget=0x00400006 on consumption: oFault=1 next cycle, oValid=0, oMemReq stays 0 indefinitely; oCount incremented once; iRST clears to reset values.
- iRST asserted while in REQ awaiting ack: outputs immediately at reset values; iMemAck pulse during reset ignored; fetch restarts at PC_RESET.
- PC_RESET=32'hFFFF_FFFC: after consumption next oMemAddr=0x00000000, no fault.
